// File: rtl/fab_clk_enable_pkg.sv
// Shared types and constants for the fabric clock-enable bank.
// No logic here; the lock FSM states and width helpers live in this package.
package fab_clk_enable_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        QUALIFY   = 2'd1,
        RUN       = 2'd2
    } state_e;

    localparam int MIN_ADDR_W = 1;
    localparam int LOCK_CNT_W = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/fab_clk_div_channel.sv
// One divider channel: shadow divisor, down-counter, registered TICK and CLK_OUT.
// First TICK D cycles after a load, then every D cycles; no backpressure.
module fab_clk_div_channel #(
    parameter int DIV_W     = 16,
    parameter int RESET_DIV = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic             sync_i,
    input  logic             we_hit_i,
    input  logic [DIV_W-1:0] wdata_i,
    output logic             tick_o,
    output logic             clk_out_o
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             act_q, act_d;
    logic             tick_q, tick_d;
    logic             clk_q, clk_d;

    always_comb begin
        div_d  = we_hit_i ? wdata_i : div_q;
        cnt_d  = cnt_q;
        act_d  = act_q;
        tick_d = 1'b0;
        clk_d  = clk_q;
        if (!run_i) begin
            cnt_d = '0;
            act_d = 1'b0;
            clk_d = 1'b0;
        end else if (sync_i) begin
            // RUN entry and SYNC share this path; a pending write is honoured
            act_d = (div_d != '0);
            cnt_d = (div_d != '0) ? div_d - DIV_W'(1) : '0;
            clk_d = 1'b0;
        end else if (!act_q) begin
            if (we_hit_i && (wdata_i != '0)) begin
                act_d = 1'b1;
                cnt_d = wdata_i - DIV_W'(1);
            end
        end else if (cnt_q == '0) begin
            tick_d = 1'b1;
            if (div_d != '0) begin
                cnt_d = div_d - DIV_W'(1);
                clk_d = ~clk_q;
            end else begin
                act_d = 1'b0;
                clk_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q  <= DIV_W'(RESET_DIV);
            cnt_q  <= '0;
            act_q  <= 1'b0;
            tick_q <= 1'b0;
            clk_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            tick_q <= tick_d;
            clk_q  <= clk_d;
        end
    end

    assign tick_o    = tick_q;
    assign clk_out_o = clk_q;

endmodule

// File: rtl/fab_clk_enable_bank.sv
// Multi-channel clock-enable generator gated by a qualified CCC lock.
// READY one edge after LOCK_CYCLES of synchronised lock; outputs drop the edge lock loss is seen.
module fab_clk_enable_bank
    import fab_clk_enable_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int LOCK_CYCLES = 256,
    parameter int RESET_DIV   = 0,
    localparam int AW = (clog2(NUM_CH) < MIN_ADDR_W) ? MIN_ADDR_W : clog2(NUM_CH)
) (
    input  logic              FAB_CLK,
    input  logic              RESET,
    input  logic              FAB_LOCK,
    input  logic              WE,
    input  logic [AW-1:0]     WADDR,
    input  logic [DIV_W-1:0]  WDATA,
    input  logic              SYNC,
    output logic              READY,
    output logic [NUM_CH-1:0] TICK,
    output logic [NUM_CH-1:0] CLK_OUT
);

    localparam logic [LOCK_CNT_W-1:0] LOCK_LAST = LOCK_CNT_W'(LOCK_CYCLES - 1);

    logic                  lk_meta_q, lk_s_q;
    state_e                state_q, state_d;
    logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic                  ready_q;
    logic                  run_nxt, sync_ld;
    logic [NUM_CH-1:0]     we_hit;

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                lock_cnt_d = '0;
                if (lk_s_q) state_d = QUALIFY;
            end
            QUALIFY: begin
                if (!lk_s_q) begin
                    state_d    = WAIT_LOCK;
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    state_d = RUN;
                end else begin
                    lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
                end
            end
            RUN: begin
                if (!lk_s_q) begin
                    state_d    = WAIT_LOCK;
                    lock_cnt_d = '0;
                end
            end
            default: begin
                state_d    = WAIT_LOCK;
                lock_cnt_d = '0;
            end
        endcase
    end

    // Channels follow the next state so outputs rise and fall on the same edge as READY
    assign run_nxt = (state_d == RUN);
    assign sync_ld = (run_nxt && (state_q != RUN)) || (SYNC && (state_q == RUN));

    always_comb begin
        we_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            we_hit[i] = WE && (32'(WADDR) == 32'(i));
        end
    end

    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            lk_meta_q  <= 1'b0;
            lk_s_q     <= 1'b0;
            state_q    <= WAIT_LOCK;
            lock_cnt_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            lk_meta_q  <= FAB_LOCK;
            lk_s_q     <= lk_meta_q;
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            ready_q    <= run_nxt;
        end
    end

    assign READY = ready_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        fab_clk_div_channel #(
            .DIV_W     (DIV_W),
            .RESET_DIV (RESET_DIV)
        ) u_ch (
            .clk_i     (FAB_CLK),
            .rst_i     (RESET),
            .run_i     (run_nxt),
            .sync_i    (sync_ld),
            .we_hit_i  (we_hit[g]),
            .wdata_i   (WDATA),
            .tick_o    (TICK[g]),
            .clk_out_o (CLK_OUT[g])
        );
    end

endmodule
